// File: rtl/qbert_video_pkg.sv
// Shared video timing constants and control-bundle type for the Q*bert LCD path.
package qbert_video_pkg;

  // Default 800x480 MTL panel timing
  localparam int unsigned DEF_H_ACTIVE   = 800;
  localparam int unsigned DEF_H_FRONT    = 40;
  localparam int unsigned DEF_H_SYNC     = 48;
  localparam int unsigned DEF_H_BACK     = 168;
  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_V_FRONT    = 13;
  localparam int unsigned DEF_V_SYNC     = 3;
  localparam int unsigned DEF_V_BACK     = 29;
  localparam int unsigned DEF_RENDER_LAT = 2;

  // Sync pulse starts right after the front porch
  function automatic int unsigned sync_start(int unsigned active, int unsigned front);
    return active + front;
  endfunction

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int unsigned DEF_HS_START = sync_start(DEF_H_ACTIVE, DEF_H_FRONT);
  localparam int unsigned DEF_HS_STOP  = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = sync_start(DEF_V_ACTIVE, DEF_V_FRONT);
  localparam int unsigned DEF_VS_STOP  = DEF_VS_START + DEF_V_SYNC;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } video_ctrl_t;

  // Syncs are active-low, so the idle bundle has them high
  localparam video_ctrl_t CTRL_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

endpackage

// File: rtl/video_delay_line.sv
// Depth-N shift register for sync/enable, matching the renderer latency.
module video_delay_line
  import qbert_video_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  video_ctrl_t din,
  output video_ctrl_t dout
);

  video_ctrl_t stage_q [N];

  // Shift one stage per clock; clear flushes every stage to idle
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < N; i++) stage_q[i] <= CTRL_IDLE;
    end else begin
      stage_q[0] <= din;
      for (int unsigned i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[N-1];

endmodule

// File: rtl/qbert_lcd_timing.sv
// Scan counter, sync decode and delay-matched panel output stage for the map renderers.
module qbert_lcd_timing
  import qbert_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter int unsigned RENDER_LAT = DEF_RENDER_LAT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] x_cnt,
  output logic [9:0]  y_cnt,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic [7:0]  lcd_r,
  output logic [7:0]  lcd_g,
  output logic [7:0]  lcd_b,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic        lcd_de,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = sync_start(H_ACTIVE, H_FRONT);
  localparam int unsigned VS_START = sync_start(V_ACTIVE, V_FRONT);

  localparam logic [10:0] XLast    = 11'(H_TOTAL - 1);
  localparam logic [10:0] XActive  = 11'(H_ACTIVE);
  localparam logic [10:0] XHsStart = 11'(HS_START);
  localparam logic [10:0] XHsStop  = 11'(HS_START + H_SYNC);
  localparam logic [9:0]  YLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  YActive  = 10'(V_ACTIVE);
  localparam logic [9:0]  YVsStart = 10'(VS_START);
  localparam logic [9:0]  YVsStop  = 10'(VS_START + V_SYNC);

  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        x_wrap, y_wrap;

  video_ctrl_t ctrl_raw, ctrl_dly;

  logic [7:0] lcd_r_q, lcd_g_q, lcd_b_q;
  logic       lcd_hsync_q, lcd_vsync_q, lcd_de_q;

  // Next-state for the scan counters and completed-frame count
  always_comb begin
    x_wrap      = (x_q == XLast);
    y_wrap      = (y_q == YLast);
    x_d         = x_wrap ? 11'd0 : x_q + 11'd1;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    if (x_wrap) begin
      y_d = y_wrap ? 10'd0 : y_q + 10'd1;
      if (y_wrap) frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Undelayed sync/enable decode from the current coordinate
  always_comb begin
    ctrl_raw.hsync = ~((x_q >= XHsStart) && (x_q < XHsStop));
    ctrl_raw.vsync = ~((y_q >= YVsStart) && (y_q < YVsStop));
    ctrl_raw.de    = (x_q < XActive) && (y_q < YActive);
  end

  video_delay_line #(
    .N(RENDER_LAT)
  ) u_delay (
    .clk  (clk),
    .clr_n(reset),
    .din  (ctrl_raw),
    .dout (ctrl_dly)
  );

  // Output stage: colour gated by the delayed enable, controls registered alongside
  always_ff @(posedge clk) begin
    if (!reset) begin
      lcd_r_q     <= '0;
      lcd_g_q     <= '0;
      lcd_b_q     <= '0;
      lcd_de_q    <= 1'b0;
      lcd_hsync_q <= 1'b1;
      lcd_vsync_q <= 1'b1;
    end else begin
      lcd_r_q     <= ctrl_dly.de ? red   : 8'd0;
      lcd_g_q     <= ctrl_dly.de ? green : 8'd0;
      lcd_b_q     <= ctrl_dly.de ? blue  : 8'd0;
      lcd_de_q    <= ctrl_dly.de;
      lcd_hsync_q <= ctrl_dly.hsync;
      lcd_vsync_q <= ctrl_dly.vsync;
    end
  end

  assign x_cnt       = x_q;
  assign y_cnt       = y_q;
  assign frame_cnt   = frame_cnt_q;
  // Gated by reset so the pulse stays low while counters are held at (0,0)
  assign frame_start = reset & (x_q == 11'd0) & (y_q == 10'd0);
  assign lcd_r       = lcd_r_q;
  assign lcd_g       = lcd_g_q;
  assign lcd_b       = lcd_b_q;
  assign lcd_de      = lcd_de_q;
  assign lcd_hsync   = lcd_hsync_q;
  assign lcd_vsync   = lcd_vsync_q;

endmodule

// File: tb/tb_qbert_lcd_timing.sv
// Scoreboard bench: three instances (latency 1, 2, 7) on a reduced 28x12 raster.
module tb_qbert_lcd_timing;

  localparam time P = 10;
  // Reduced geometry: H 16+4+3+5=28, V 6+2+2+2=12, frame = 336 clocks
  localparam int HT = 28;
  localparam int VT = 12;

  typedef struct {
    time        due;
    logic       de, hs, vs;
    logic [7:0] r, g, b;
  } exp_t;

  logic clk = 1'b0;
  always #(P/2) clk = ~clk;

  logic reset;
  logic [7:0] red1, grn1, red2, grn2, red7, grn7;
  logic [7:0] blu = 8'h33;

  logic [10:0] x1, x2, x7;
  logic [9:0]  y1, y2, y7;
  logic [7:0]  r1, g1, b1, r2, g2, b2, r7, g7, b7;
  logic        hs1, vs1, de1, fs1, hs2, vs2, de2, fs2, hs7, vs7, de7, fs7;
  logic [15:0] f1, f2, f7;

  qbert_lcd_timing #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(3), .H_BACK(5),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .RENDER_LAT(1)
  ) u1 (
    .clk(clk), .reset(reset), .x_cnt(x1), .y_cnt(y1),
    .red(red1), .green(grn1), .blue(blu),
    .lcd_r(r1), .lcd_g(g1), .lcd_b(b1), .lcd_hsync(hs1), .lcd_vsync(vs1),
    .lcd_de(de1), .frame_start(fs1), .frame_cnt(f1)
  );

  qbert_lcd_timing #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(3), .H_BACK(5),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .RENDER_LAT(2)
  ) u2 (
    .clk(clk), .reset(reset), .x_cnt(x2), .y_cnt(y2),
    .red(red2), .green(grn2), .blue(blu),
    .lcd_r(r2), .lcd_g(g2), .lcd_b(b2), .lcd_hsync(hs2), .lcd_vsync(vs2),
    .lcd_de(de2), .frame_start(fs2), .frame_cnt(f2)
  );

  qbert_lcd_timing #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(3), .H_BACK(5),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .RENDER_LAT(7)
  ) u7 (
    .clk(clk), .reset(reset), .x_cnt(x7), .y_cnt(y7),
    .red(red7), .green(grn7), .blue(blu),
    .lcd_r(r7), .lcd_g(g7), .lcd_b(b7), .lcd_hsync(hs7), .lcd_vsync(vs7),
    .lcd_de(de7), .frame_start(fs7), .frame_cnt(f7)
  );

  int vectors = 0;
  int miscompares = 0;

  exp_t q1[$], q2[$], q7[$];

  // Reference raster state
  int          rx = 0, ry = 0;
  logic [15:0] rf = 16'd0;
  logic [15:0] hist [8];

  // Expected panel outputs for pixel (x,y), hand-derived from the reduced windows
  function automatic exp_t pixel(int x, int y, time due);
    exp_t e;
    e.due = due;
    e.de  = (x < 16) && (y < 6);
    e.hs  = !((x >= 20) && (x < 23));
    e.vs  = !((y >= 8) && (y < 10));
    e.r   = e.de ? 8'(x) : 8'd0;
    e.g   = e.de ? 8'(y) : 8'd0;
    e.b   = e.de ? 8'h33 : 8'd0;
    return e;
  endfunction

  function automatic exp_t idle(time due);
    exp_t e;
    e.due = due;
    e.de  = 1'b0;
    e.hs  = 1'b1;
    e.vs  = 1'b1;
    e.r   = 8'd0;
    e.g   = 8'd0;
    e.b   = 8'd0;
    return e;
  endfunction

  task automatic check_px(input string name, input exp_t e, input logic de, input logic hs,
                          input logic vs, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b);
    vectors++;
    if ({de, hs, vs, r, g, b} !== {e.de, e.hs, e.vs, e.r, e.g, e.b}) begin
      miscompares++;
      $display("FAIL %s pixel t=%0t got de=%b hs=%b vs=%b rgb=%h/%h/%h want de=%b hs=%b vs=%b rgb=%h/%h/%h",
               name, $time, de, hs, vs, r, g, b, e.de, e.hs, e.vs, e.r, e.g, e.b);
    end
  endtask

  task automatic check_ctr(input string name, input logic [10:0] x, input logic [9:0] y,
                           input logic [15:0] f, input logic fs);
    logic fs_exp;
    fs_exp = reset && (rx == 0) && (ry == 0);
    vectors++;
    if (x !== 11'(rx) || y !== 10'(ry) || f !== rf || fs !== fs_exp) begin
      miscompares++;
      $display("FAIL %s counters t=%0t got x=%0d y=%0d fcnt=%h fs=%b want x=%0d y=%0d fcnt=%h fs=%b",
               name, $time, x, y, f, fs, rx, ry, rf, fs_exp);
    end
  endtask

  // Monitor: pop every expectation that falls due on this sample point
  always @(negedge clk) begin
    exp_t e;
    while (q1.size() > 0 && q1[0].due <= $time) begin
      e = q1.pop_front();
      check_px("lat1", e, de1, hs1, vs1, r1, g1, b1);
    end
    while (q2.size() > 0 && q2[0].due <= $time) begin
      e = q2.pop_front();
      check_px("lat2", e, de2, hs2, vs2, r2, g2, b2);
    end
    while (q7.size() > 0 && q7[0].due <= $time) begin
      e = q7.pop_front();
      check_px("lat7", e, de7, hs7, vs7, r7, g7, b7);
    end
  end

  // One clock of stimulus, entered and left at a falling edge
  task automatic step(input logic rst_val, input logic force_wrap);
    check_ctr("lat1", x1, y1, f1, fs1);
    check_ctr("lat2", x2, y2, f2, fs2);
    check_ctr("lat7", x7, y7, f7, fs7);

    // Renderer model: colour = coordinate low bytes, returned after its latency
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {x2[7:0], y2[7:0]};
    red1 = hist[1][15:8]; grn1 = hist[1][7:0];
    red2 = hist[2][15:8]; grn2 = hist[2][7:0];
    red7 = hist[7][15:8]; grn7 = hist[7][7:0];

    reset = rst_val;
    q1.push_back(pixel(rx, ry, $time + 2 * P));
    q2.push_back(pixel(rx, ry, $time + 3 * P));
    q7.push_back(pixel(rx, ry, $time + 8 * P));
    // A reset edge flushes everything still in flight
    if (!rst_val) begin
      foreach (q1[i]) if (q1[i].due > $time) q1[i] = idle(q1[i].due);
      foreach (q2[i]) if (q2[i].due > $time) q2[i] = idle(q2[i].due);
      foreach (q7[i]) if (q7[i].due > $time) q7[i] = idle(q7[i].due);
    end

    @(posedge clk);
    if (!rst_val) begin
      rx = 0; ry = 0; rf = 16'd0;
    end else if (rx == HT - 1) begin
      rx = 0;
      if (ry == VT - 1) begin
        ry = 0;
        rf = rf + 16'd1;
      end else begin
        ry = ry + 1;
      end
    end else begin
      rx = rx + 1;
    end

    if (force_wrap) begin
      #1;
      force u1.frame_cnt_q = 16'hFFFF;
      force u2.frame_cnt_q = 16'hFFFF;
      force u7.frame_cnt_q = 16'hFFFF;
      #1;
      release u1.frame_cnt_q;
      release u2.frame_cnt_q;
      release u7.frame_cnt_q;
      rf = 16'hFFFF;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    red1 = '0; grn1 = '0; red2 = '0; grn2 = '0; red7 = '0; grn7 = '0;
    foreach (hist[i]) hist[i] = '0;
    @(negedge clk);
    repeat (4) step(1'b0, 1'b0);

    // Two full frames plus a margin
    repeat (2 * HT * VT + 20) step(1'b1, 1'b0);

    // Mid-frame reset at the scaled equivalent of (400,200)
    while (!(rx == 8 && ry == 3)) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (HT * VT + 10) step(1'b1, 1'b0);

    // Preload the frame counter to all-ones, then run through the wrap
    while (!(rx == 5 && ry == 4)) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (HT * VT + 10) step(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/qbert_lcd_timing.md
# qbert_lcd_timing

Display timing source and pixel sink for the Q*bert map renderers. It generates the `x_cnt`/`y_cnt` scan coordinates that the map renderers consume. It takes their registered `red`/`green`/`blue` back after a fixed render latency and drives the 800x480 MTL panel. Sync and data-enable are delay-matched to the returned colour.

## Interface
Parameters:
- `H_ACTIVE`, 800: visible pixels per line.
- `H_FRONT`, 40: horizontal front porch, in clocks.
- `H_SYNC`, 48: horizontal sync width, in clocks.
- `H_BACK`, 168: horizontal back porch; line total is 1056.
- `V_ACTIVE`, 480: visible lines.
- `V_FRONT`, 13: vertical front porch, in lines.
- `V_SYNC`, 3: vertical sync width, in lines.
- `V_BACK`, 29: vertical back porch; frame total is 525.
- `RENDER_LAT`, 2: clocks from `x_cnt`/`y_cnt` to valid `red`/`green`/`blue`. Legal range is 1..7.

Ports:
- `clk`, in, 1: pixel clock.
- `reset`, in, 1: reset, synchronous and active-low.
- `x_cnt`, out, 11: horizontal counter, 0..1055.
- `y_cnt`, out, 10: vertical counter, 0..524.
- `red`, `green`, `blue`, in, 8 each: renderer colour, valid `RENDER_LAT` clocks after the matching coordinate.
- `lcd_r`, `lcd_g`, `lcd_b`, out, 8 each: panel colour, forced to 0 outside the active area.
- `lcd_hsync`, `lcd_vsync`, out, 1 each: panel syncs, active-low.
- `lcd_de`, out, 1: data enable, high for active pixels.
- `frame_start`, out, 1: one-clock pulse when `x_cnt`=0 and `y_cnt`=0.
- `frame_cnt`, out, 16: number of completed frames, wrapping.

## Operation
- `x_cnt` increments every clock. At `H_TOTAL`-1 it wraps to 0.
- `y_cnt` increments only on the clock where `x_cnt` wraps. At `V_TOTAL`-1 it wraps to 0.
- Horizontal regions:
  - active: 0..799
  - front porch: 800..839
  - sync: 840..887, where the undelayed hsync is 0
  - back porch: 888..1055
- Vertical regions:
  - active: 0..479
  - front porch: 480..492
  - sync: 493..495, where the undelayed vsync is 0
  - back porch: 496..524
- Undelayed enable: de_raw = (`x_cnt` < `H_ACTIVE`) && (`y_cnt` < `V_ACTIVE`).
- hsync_raw, vsync_raw and de_raw are decoded combinationally from the current counters. They then pass through a `RENDER_LAT`-deep shift register, so output alignment is exact.
- Output stage: `lcd_r`/`lcd_g`/`lcd_b` are registered from `red`/`green`/`blue` when the delayed de is 1, and set to 0 otherwise. The delayed syncs and de are registered in the same stage, so the colour and control outputs stay aligned.
- `frame_cnt` increments by 1 on the clock where both counters wrap. It wraps from 0xFFFF to 0.
- Counter arithmetic is unsigned at the port widths. Counters never exceed their totals.

## Timing
- While `reset`=0 at a clock edge, the following are forced on that edge:
  - `x_cnt`, `y_cnt` and `frame_cnt` = 0.
  - All delay-line stages = inactive: sync 1, de 0.
  - `lcd_r`/`lcd_g`/`lcd_b` = 0, `lcd_de` = 0, `lcd_hsync` = `lcd_vsync` = 1.
  - `frame_start` = 0.
- First clock after reset release: `x_cnt`=0, `y_cnt`=0, `frame_start`=1.
- Latency from coordinate (x,y) to the panel outputs for that pixel is `RENDER_LAT`+1 clocks. This covers `lcd_r`/`lcd_g`/`lcd_b`, `lcd_de`, `lcd_hsync` and `lcd_vsync`.
- Reset mid-frame restarts at (0,0) on the next clock. Nothing from the aborted frame may reach the panel:
  - The delay line is cleared, so `lcd_de` stays 0 for `RENDER_LAT`+1 clocks.
  - `frame_cnt` is cleared, not incremented.
- `frame_start` is combinational from the counters (`x_cnt`=0 and `y_cnt`=0) and is held low while `reset`=0.
- On the clock where both counters wrap, the `frame_cnt` increment and the `frame_start` pulse on the following clock are simultaneous with the (0,0) coordinate.

## Structure
- Package `qbert_video_pkg` holds:
  - the default timing constants;
  - the derived `H_TOTAL`/`V_TOTAL` and the sync start/stop positions;
  - a `video_ctrl_t` packed struct {hsync, vsync, de}.
- Sub-module `video_delay_line`: a parameterised depth-N shift register of `video_ctrl_t`, with synchronous active-low clear to the inactive value. It is instantiated once with N=`RENDER_LAT`.
- The top level contains the counters, decode, output register and frame counter.

## Test plan
- Release reset, run 2 frames with a constant renderer colour of (0x11,0x22,0x33). Required:
  - `x_cnt` sequence 0..1055 repeating.
  - `y_cnt` steps once per line, wrapping at 524.
  - `frame_start` pulses every 554400 clocks.
  - `frame_cnt`=2 after 1108800 clocks.
- Check sync windows:
  - `lcd_hsync` is 0 for exactly 48 clocks per line, first low 843 clocks after `x_cnt`=0 (`RENDER_LAT`=2).
  - `lcd_vsync` is 0 for exactly 3 lines.
- Renderer model returns `red`=x[7:0] delayed 2 clocks. Required: `lcd_r` equals the low byte of the panel column at every `lcd_de`=1 clock; `lcd_r`=0 whenever `lcd_de`=0.
- Assert `reset`=0 for 1 clock at (400,200). Required:
  - next clock: `x_cnt`=0, `y_cnt`=0, `frame_cnt`=0;
  - `lcd_de` stays 0 for 3 clocks;
  - no stale colour appears on `lcd_r`/`lcd_g`/`lcd_b`.
- Repeat the alignment test with `RENDER_LAT`=1 and 7. Required: zero misaligned pixels; output latency 2 and 8 clocks respectively.
- Force `frame_cnt` to 0xFFFF and complete one frame. Required: `frame_cnt`=0x0000 and `frame_start`=1 on the same clock.
